// File: rtl/johnson_phase_sequencer_pkg.sv
// Shared types and Johnson-code helpers for the phase sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package johnson_seq_pkg;

    localparam int RING_W      = 8;
    localparam int RING_STATES = 2 * RING_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Ring code -> phase index. Filling with ones from the MSB counts up,
    // then draining ones from the MSB counts on from RING_W.
    function automatic logic [3:0] johnson_decode(input logic [RING_W-1:0] r);
        logic [4:0] pop;
        logic [4:0] rem;
        pop = '0;
        for (int i = 0; i < RING_W; i++) begin
            pop = pop + {4'd0, r[i]};
        end
        rem = 5'd16 - pop;
        if (r == '0) begin
            return 4'd0;
        end else if (r[RING_W-1]) begin
            return pop[3:0];
        end else begin
            return rem[3:0];
        end
    endfunction

    // Legal Johnson codes are 1..10..0 or 0..01..1: at most one boundary
    // between adjacent bits.
    function automatic logic johnson_legal(input logic [RING_W-1:0] r);
        int trans;
        trans = 0;
        for (int i = 0; i < RING_W - 1; i++) begin
            if (r[i] != r[i+1]) begin
                trans = trans + 1;
            end
        end
        return (trans <= 1);
    endfunction

endpackage

// File: rtl/johnson_phase_sequencer_if.sv
// Control/status bundle between a run requester and the phase sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while the sequencer is busy.
interface johnson_phase_sequencer_if #(
    parameter int RW   = johnson_seq_pkg::RING_W,
    parameter int RNDW = 8
) ();
    logic            start;
    logic            abort;
    logic            hold;
    logic            dir;
    logic [4:0]      num_steps;
    logic [RNDW-1:0] num_rounds;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [RW-1:0]   ring;
    logic [3:0]      phase;
    logic [RNDW-1:0] round_idx;
    logic            ring_err;

    // Requester side: issues run requests, observes ring and status.
    modport master (
        output start, abort, hold, dir, num_steps, num_rounds,
        input  busy, done, aborted, ring, phase, round_idx, ring_err
    );

    // Sequencer side.
    modport slave (
        input  start, abort, hold, dir, num_steps, num_rounds,
        output busy, done, aborted, ring, phase, round_idx, ring_err
    );
endinterface

// File: rtl/johnson_phase_sequencer_ring_core.sv
// Enabled, reversible Johnson counter; clear has priority over step.
// Latency: ring updates on the edge after step/clear is presented.
// Backpressure: ring holds its value while neither step nor clear is asserted.
module johnson_ring_core
    import johnson_seq_pkg::*;
#(
    parameter int RW = RING_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_step,
    input  logic          i_clear,
    input  logic          i_dir,
    output logic [RW-1:0] o_ring
);

    logic [RW-1:0] r_ring;

    // Ring register: clear wins, otherwise shift one position in the selected direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ring <= '0;
        end else if (i_clear) begin
            r_ring <= '0;
        end else if (i_step) begin
            if (i_dir) begin
                r_ring <= {r_ring[RW-2:0], ~r_ring[RW-1]};
            end else begin
                r_ring <= {~r_ring[0], r_ring[RW-1:1]};
            end
        end
    end

    assign o_ring = r_ring;

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Run controller stepping a Johnson ring for N steps x M rounds, then pulsing done.
// Latency: start edge -> RUN; first ring step one edge later; done after 1 + rounds*steps edges.
// Backpressure: hold freezes ring and counters; abort cancels from RUN/DONE.
module johnson_phase_sequencer
    import johnson_seq_pkg::*;
#(
    parameter int RW   = RING_W,
    parameter int RNDW = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    johnson_phase_sequencer_if.slave   bus
);

    seq_state_t      r_state;
    logic            r_dir;
    logic [3:0]      r_steps_m1;
    logic [3:0]      r_step_cnt;
    logic [RNDW-1:0] r_rounds_m1;
    logic [RNDW-1:0] r_round_idx;
    logic            r_done;
    logic            r_aborted;
    logic            r_ring_err;

    logic [RW-1:0]   w_ring;
    logic            w_legal;
    logic            w_start_acc;
    logic            w_abort_acc;
    logic            w_go;
    logic            w_last;
    logic            w_more;
    logic            w_step;
    logic            w_clear;
    logic [3:0]      w_steps_m1_in;
    logic [RNDW-1:0] w_rounds_m1_in;
    logic [4:0]      w_steps_dec;

    // Normalise programmed counts to "minus one" form: 0 or >16 steps means 16, 0 rounds means 1.
    always_comb begin
        w_steps_dec    = bus.num_steps - 5'd1;
        w_steps_m1_in  = 4'hF;
        w_rounds_m1_in = '0;
        if (bus.num_steps != 5'd0 && bus.num_steps <= 5'd16) begin
            w_steps_m1_in = w_steps_dec[3:0];
        end
        if (bus.num_rounds != '0) begin
            w_rounds_m1_in = bus.num_rounds - RNDW'(1);
        end
    end

    assign w_legal     = johnson_legal(w_ring);
    assign w_start_acc = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_abort_acc = (r_state != IDLE) && bus.abort;
    assign w_go        = (r_state == RUN) && !bus.hold && !bus.abort && w_legal;
    assign w_last      = (r_step_cnt == r_steps_m1);
    assign w_more      = (r_round_idx < r_rounds_m1);

    // The last step of a non-final round is replaced by a clear so every round begins at phase 0.
    assign w_step  = w_go && !(w_last && w_more);
    assign w_clear = (r_state == IDLE) || !w_legal || w_abort_acc || (w_go && w_last && w_more);

    johnson_ring_core #(.RW(RW)) u_ring (
        .clk     (clk),
        .reset   (reset),
        .i_step  (w_step),
        .i_clear (w_clear),
        .i_dir   (r_dir),
        .o_ring  (w_ring)
    );

    // Sequencer FSM with step/round counters and registered status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_steps_m1  <= 4'hF;
            r_step_cnt  <= '0;
            r_rounds_m1 <= '0;
            r_round_idx <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_ring_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;

            if (!w_legal) begin
                r_ring_err <= 1'b1;
            end else if (w_start_acc) begin
                r_ring_err <= 1'b0;
            end

            if (w_abort_acc) begin
                r_state     <= IDLE;
                r_step_cnt  <= '0;
                r_round_idx <= '0;
                r_aborted   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start_acc) begin
                            r_state     <= RUN;
                            r_dir       <= bus.dir;
                            r_steps_m1  <= w_steps_m1_in;
                            r_rounds_m1 <= w_rounds_m1_in;
                            r_step_cnt  <= '0;
                            r_round_idx <= '0;
                        end
                    end
                    RUN: begin
                        if (!w_legal) begin
                            r_step_cnt <= '0;
                        end else if (!bus.hold) begin
                            if (w_last) begin
                                r_step_cnt <= '0;
                                if (w_more) begin
                                    r_round_idx <= r_round_idx + RNDW'(1);
                                end else begin
                                    r_state <= DONE;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_step_cnt <= r_step_cnt + 4'd1;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.aborted   = r_aborted;
    assign bus.ring      = w_ring;
    assign bus.phase     = johnson_decode(w_ring);
    assign bus.round_idx = r_round_idx;
    assign bus.ring_err  = r_ring_err;

endmodule
